// File: rtl/store_buffer_lsu_pkg.sv
// Shared types for the load/store front end: memory port structs, store buffer entry,
// default sizing and the port arbitration decision.
package store_buffer_lsu_pkg;

  localparam int unsigned SB_DEPTH  = 4;
  localparam int unsigned MEM_IDX_W = 5;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic        MemWrite;
    logic        MemRead;
    logic        valid;
  } memReqStruct;

  typedef struct packed {
    logic [31:0] rd_data;
  } memRespStruct;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] data;
  } sbEntryStruct;

  typedef enum logic [1:0] {
    PORT_IDLE,
    PORT_LOAD,
    PORT_DRAIN
  } portOpEnum;

endpackage

// File: rtl/store_buffer_lsu_fwd_check.sv
// Store-to-load forwarding search: finds the youngest buffered or incoming store that
// overlaps the load and reports an exact hit (forwardable) or a partial hit (stall).
module sb_fwd_check
  import store_buffer_lsu_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH,
  parameter int unsigned IDX_W = MEM_IDX_W
) (
  input  sbEntryStruct               i_entries [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]   i_head,
  input  logic                       i_st_enq,
  input  logic [31:0]                i_st_addr,
  input  logic [31:0]                i_st_data,
  input  logic [31:0]                i_ld_addr,
  output logic                       o_fwd_hit,
  output logic                       o_partial_hit,
  output logic [31:0]                o_fwd_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  function automatic logic overlaps(input logic [IDX_W-1:0] a, input logic [IDX_W-1:0] b);
    logic [IDX_W-1:0] d_ab;
    logic [IDX_W-1:0] d_ba;
    d_ab = a - b;
    d_ba = b - a;
    return (d_ab < IDX_W'(4)) || (d_ba < IDX_W'(4));
  endfunction

  logic [PTR_W-1:0] w_idx;
  logic             w_unused_hi;

  // Walking oldest to youngest and letting later hits overwrite earlier ones yields the
  // same result as a youngest-first priority search from tail-1 back to head.
  always_comb begin
    o_fwd_hit     = 1'b0;
    o_partial_hit = 1'b0;
    o_fwd_data    = '0;
    w_idx         = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_idx = i_head + PTR_W'(k);
      if (i_entries[w_idx].valid &&
          overlaps(i_entries[w_idx].addr[IDX_W-1:0], i_ld_addr[IDX_W-1:0])) begin
        o_fwd_hit     = (i_entries[w_idx].addr[IDX_W-1:0] == i_ld_addr[IDX_W-1:0]);
        o_partial_hit = !o_fwd_hit;
        o_fwd_data    = i_entries[w_idx].data;
      end
    end
    if (i_st_enq && overlaps(i_st_addr[IDX_W-1:0], i_ld_addr[IDX_W-1:0])) begin
      o_fwd_hit     = (i_st_addr[IDX_W-1:0] == i_ld_addr[IDX_W-1:0]);
      o_partial_hit = !o_fwd_hit;
      o_fwd_data    = i_st_data;
    end
  end

  always_comb begin
    w_unused_hi = ^{i_st_addr[31:IDX_W], i_ld_addr[31:IDX_W]};
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_unused_hi = w_unused_hi ^ (^i_entries[k].addr[31:IDX_W]);
    end
  end

endmodule

// File: rtl/store_buffer_lsu.sv
// Load/store front end: in-order store buffer draining to one memory port, loads sharing
// that port with store-to-load forwarding and a one-cycle tagged load response.
module store_buffer_lsu
  import store_buffer_lsu_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH,
  parameter int unsigned TAG_W = 6,
  parameter int unsigned IDX_W = MEM_IDX_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [31:0]              st_addr,
  input  logic [31:0]              st_data,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [31:0]              ld_addr,
  input  logic [TAG_W-1:0]         ld_tag,
  output logic                     ld_resp_valid,
  output logic [TAG_W-1:0]         ld_resp_tag,
  output logic [31:0]              ld_resp_data,
  output memReqStruct              mem_req,
  input  memRespStruct             mem_resp,
  output logic [$clog2(DEPTH):0]   sb_count,
  output logic                     sb_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  sbEntryStruct     r_entries [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             r_resp_valid;
  logic [TAG_W-1:0] r_resp_tag;
  logic [31:0]      r_resp_data;

  logic             w_full;
  logic             w_enq;
  logic             w_ld_fire;
  logic             w_drain;
  logic             w_fwd_hit;
  logic             w_partial_hit;
  logic [31:0]      w_fwd_data;
  logic [31:0]      w_ld_data;
  portOpEnum        w_port_op;

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign st_ready  = !w_full;
  assign w_enq     = st_valid && st_ready;
  assign ld_ready  = !reset && !w_full && !w_partial_hit;
  assign w_ld_fire = ld_valid && ld_ready;
  assign w_ld_data = w_fwd_hit ? w_fwd_data : mem_resp.rd_data;
  assign w_drain   = (w_port_op == PORT_DRAIN);

  assign sb_count      = r_count;
  assign sb_empty      = (r_count == '0);
  assign ld_resp_valid = r_resp_valid;
  assign ld_resp_tag   = r_resp_tag;
  assign ld_resp_data  = r_resp_data;

  sb_fwd_check #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_fwd_check (
    .i_entries     (r_entries),
    .i_head        (r_head),
    .i_st_enq      (w_enq),
    .i_st_addr     (st_addr),
    .i_st_data     (st_data),
    .i_ld_addr     (ld_addr),
    .o_fwd_hit     (w_fwd_hit),
    .o_partial_hit (w_partial_hit),
    .o_fwd_data    (w_fwd_data)
  );

  always_comb begin
    w_port_op = PORT_IDLE;
    if (w_ld_fire) begin
      w_port_op = PORT_LOAD;
    end else if (!reset && r_count != '0) begin
      w_port_op = PORT_DRAIN;
    end
  end

  always_comb begin
    mem_req = '0;
    case (w_port_op)
      PORT_LOAD: begin
        mem_req.addr    = ld_addr;
        mem_req.MemRead = 1'b1;
        mem_req.valid   = 1'b1;
      end
      PORT_DRAIN: begin
        mem_req.addr     = r_entries[r_head].addr;
        mem_req.wr_data  = r_entries[r_head].data;
        mem_req.MemWrite = 1'b1;
        mem_req.valid    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        r_entries[k] <= '0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) begin
        r_entries[r_tail] <= '{valid: 1'b1, addr: st_addr, data: st_data};
        r_tail            <= r_tail + PTR_W'(1);
      end
      if (w_drain) begin
        r_entries[r_head].valid <= 1'b0;
        r_head                  <= r_head + PTR_W'(1);
      end
      case ({w_enq, w_drain})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_resp_valid <= 1'b0;
      r_resp_tag   <= '0;
      r_resp_data  <= '0;
    end else begin
      r_resp_valid <= w_ld_fire;
      if (w_ld_fire) begin
        r_resp_tag  <= ld_tag;
        r_resp_data <= w_ld_data;
      end
    end
  end

endmodule

// File: tb/tb_store_buffer_lsu.sv
// Directed bench for store_buffer_lsu against a 32-byte little-endian memory model.
module tb_store_buffer_lsu;
  import store_buffer_lsu_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         st_valid;
  logic         st_ready;
  logic [31:0]  st_addr;
  logic [31:0]  st_data;
  logic         ld_valid;
  logic         ld_ready;
  logic [31:0]  ld_addr;
  logic [5:0]   ld_tag;
  logic         ld_resp_valid;
  logic [5:0]   ld_resp_tag;
  logic [31:0]  ld_resp_data;
  memReqStruct  mem_req;
  memRespStruct mem_resp;
  logic [2:0]   sb_count;
  logic         sb_empty;

  logic [7:0]   mem [32];
  logic         mem_init;
  int unsigned  wr_count = 0;
  int unsigned  wr_saved;
  int           errors = 0;
  int           checks = 0;

  always #5 clk = ~clk;

  store_buffer_lsu #(
    .DEPTH (4),
    .TAG_W (6),
    .IDX_W (5)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .st_valid      (st_valid),
    .st_ready      (st_ready),
    .st_addr       (st_addr),
    .st_data       (st_data),
    .ld_valid      (ld_valid),
    .ld_ready      (ld_ready),
    .ld_addr       (ld_addr),
    .ld_tag        (ld_tag),
    .ld_resp_valid (ld_resp_valid),
    .ld_resp_tag   (ld_resp_tag),
    .ld_resp_data  (ld_resp_data),
    .mem_req       (mem_req),
    .mem_resp      (mem_resp),
    .sb_count      (sb_count),
    .sb_empty      (sb_empty)
  );

  // Memory starts with byte i == i; writes and reads wrap modulo 32 bytes.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'(i);
    end else if (mem_req.valid && mem_req.MemWrite) begin
      for (int k = 0; k < 4; k++) mem[5'(mem_req.addr[4:0] + 5'(k))] <= mem_req.wr_data[8*k +: 8];
      wr_count <= wr_count + 1;
    end
  end

  always_comb begin
    mem_resp = '0;
    for (int k = 0; k < 4; k++) mem_resp.rd_data[8*k +: 8] = mem[5'(mem_req.addr[4:0] + 5'(k))];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_wr(input string tag, input logic [31:0] a, input logic [31:0] d);
    chk({tag, "_wr"}, 32'(mem_req.valid && mem_req.MemWrite && !mem_req.MemRead), 1);
    chk({tag, "_addr"}, mem_req.addr, a);
    chk({tag, "_data"}, mem_req.wr_data, d);
  endtask

  task automatic chk_resp(input string tag, input logic [5:0] t, input logic [31:0] d);
    chk({tag, "_valid"}, 32'(ld_resp_valid), 1);
    chk({tag, "_tag"}, 32'(ld_resp_tag), 32'(t));
    chk({tag, "_data"}, ld_resp_data, d);
  endtask

  initial begin
    reset = 1'b1; mem_init = 1'b1;
    st_valid = 1'b0; st_addr = '0; st_data = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_tag = '0;
    @(negedge clk); next(); #1;
    chk("rst_count", 32'(sb_count), 0);
    chk("rst_empty", 32'(sb_empty), 1);
    chk("rst_resp_valid", 32'(ld_resp_valid), 0);
    chk("rst_resp_tag", 32'(ld_resp_tag), 0);
    chk("rst_resp_data", ld_resp_data, 0);
    chk("rst_memreq_zero", 32'(mem_req == '0), 1);
    chk("rst_ld_ready", 32'(ld_ready), 0);
    reset = 1'b0; mem_init = 1'b0; #1;
    chk("idle_st_ready", 32'(st_ready), 1);
    chk("idle_ld_ready", 32'(ld_ready), 1);

    // Basic drain
    st_valid = 1'b1; st_addr = 32'h4; st_data = 32'hDEADBEEF; #1;
    chk("t1_no_req", 32'(mem_req.valid), 0);
    next(); st_valid = 1'b0; #1;
    chk("t1_count1", 32'(sb_count), 1);
    chk_wr("t1_drain", 32'h4, 32'hDEADBEEF);
    next(); #1;
    chk("t1_count0", 32'(sb_count), 0);
    chk("t1_empty", 32'(sb_empty), 1);
    ld_valid = 1'b1; ld_addr = 32'h4; ld_tag = 6'd5; #1;
    chk("t1_ld_ready", 32'(ld_ready), 1);
    chk("t1_rd", 32'(mem_req.valid && mem_req.MemRead && !mem_req.MemWrite), 1);
    next(); ld_valid = 1'b0; #1;
    chk_resp("t1_resp", 6'd5, 32'hDEADBEEF);
    next(); #1;
    chk("t1_resp_drop", 32'(ld_resp_valid), 0);
    chk("t1_tag_hold", 32'(ld_resp_tag), 5);

    // Exact forwarding, loads held so nothing drains
    ld_valid = 1'b1; ld_addr = 32'h14; ld_tag = 6'd1;
    st_valid = 1'b1; st_addr = 32'h8; st_data = 32'h11111111;
    next(); ld_tag = 6'd2; st_data = 32'h22222222; #1;
    chk_resp("t2_mem_ld", 6'd1, 32'h17161514);
    next(); st_valid = 1'b0; ld_addr = 32'h8; ld_tag = 6'd3; #1;
    chk("t2_count2", 32'(sb_count), 2);
    chk("t2_ld_ready", 32'(ld_ready), 1);
    chk("t2_rd_addr", mem_req.addr, 32'h8);
    next(); ld_valid = 1'b0; #1;
    chk_resp("t2_fwd", 6'd3, 32'h22222222);
    chk("t2_mem_untouched", {mem[11], mem[10], mem[9], mem[8]}, 32'h0B0A0908);
    chk_wr("t2_drain_old", 32'h8, 32'h11111111);
    next(); #1;
    chk_wr("t2_drain_young", 32'h8, 32'h22222222);
    next(); #1;
    chk("t2_count0", 32'(sb_count), 0);

    // Partial overlap stall
    st_valid = 1'b1; st_addr = 32'h8; st_data = 32'h44332211;
    ld_valid = 1'b1; ld_addr = 32'hA; ld_tag = 6'd7; #1;
    chk("t3_stall_incoming", 32'(ld_ready), 0);
    next(); st_valid = 1'b0; #1;
    chk("t3_stall_buffered", 32'(ld_ready), 0);
    chk_wr("t3_drain", 32'h8, 32'h44332211);
    next(); #1;
    chk("t3_count0", 32'(sb_count), 0);
    chk("t3_ready", 32'(ld_ready), 1);
    next(); ld_valid = 1'b0; #1;
    chk_resp("t3_resp", 6'd7, 32'h0D0C4433);

    // Wrap-around overlap
    st_valid = 1'b1; st_addr = 32'h1E; st_data = 32'hA5A5A5A5;
    next(); st_valid = 1'b0; ld_valid = 1'b1; ld_addr = 32'h0; ld_tag = 6'd9; #1;
    chk("t4_wrap_stall", 32'(ld_ready), 0);
    chk_wr("t4_drain", 32'h1E, 32'hA5A5A5A5);
    next(); #1;
    chk("t4_ready", 32'(ld_ready), 1);
    next(); ld_valid = 1'b0; st_valid = 1'b1; st_addr = 32'h1C; st_data = 32'hCAFEF00D; #1;
    chk_resp("t4_wrap_mem", 6'd9, 32'h0302A5A5);
    next(); st_valid = 1'b0; ld_valid = 1'b1; ld_addr = 32'h3C; ld_tag = 6'h2A; #1;
    chk("t4_trunc_ready", 32'(ld_ready), 1);
    next(); ld_valid = 1'b0; #1;
    chk_resp("t4_trunc_fwd", 6'h2A, 32'hCAFEF00D);
    chk_wr("t4_drain2", 32'h1C, 32'hCAFEF00D);

    // Full-buffer priority with loads held high
    next(); ld_valid = 1'b1; ld_addr = 32'h10; ld_tag = 6'd10;
    st_valid = 1'b1; st_addr = 32'h0; st_data = 32'h1;
    next(); st_addr = 32'h4; st_data = 32'h2;
    next(); st_addr = 32'h18; st_data = 32'h3;
    next(); st_addr = 32'h1C; st_data = 32'h4;
    next(); st_addr = 32'h8; st_data = 32'h5; #1;
    chk("t5_count4", 32'(sb_count), 4);
    chk("t5_st_ready", 32'(st_ready), 0);
    chk("t5_ld_ready", 32'(ld_ready), 0);
    chk_wr("t5_drain", 32'h0, 32'h1);
    next(); #1;
    chk("t5_count3", 32'(sb_count), 3);
    chk("t5_st_ready3", 32'(st_ready), 1);
    chk("t5_ld_ready3", 32'(ld_ready), 1);
    next(); st_valid = 1'b0; ld_valid = 1'b0; #1;
    chk("t5_refill", 32'(sb_count), 4);
    chk_wr("t5_drain2", 32'h4, 32'h2);

    // Reset mid-operation
    next(); ld_valid = 1'b1; ld_tag = 6'h33; #1;
    chk("t6_count3", 32'(sb_count), 3);
    chk("t6_ld_fire", 32'(ld_ready), 1);
    next(); reset = 1'b1; #1;
    wr_saved = wr_count;
    chk_resp("t6_inflight", 6'h33, 32'h13121110);
    chk("t6_rst_noreq", 32'(mem_req.valid), 0);
    next(); reset = 1'b0; ld_valid = 1'b0; #1;
    chk("t6_count0", 32'(sb_count), 0);
    chk("t6_empty", 32'(sb_empty), 1);
    chk("t6_resp_valid", 32'(ld_resp_valid), 0);
    chk("t6_resp_tag", 32'(ld_resp_tag), 0);
    chk("t6_memreq", 32'(mem_req.valid), 0);
    for (int i = 0; i < 4; i++) next();
    #1;
    chk("t6_no_drain_after", wr_count, wr_saved);
    chk("t6_mem18", {mem[27], mem[26], mem[25], mem[24]}, 32'h1B1A1918);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
